ifu_fq: RTL and testbench

Parametrised instruction fetch unit with a decoupled fetch queue, sitting between the instruction memory and decode. It issues in-order fetch requests under a credit limit, absorbs memory latency in a FQ_DEPTH-entry FIFO, and steers the next fetch address with an external branch predictor. On an EXU redirect it discards stale in-flight responses with a drop counter, so the memory interface may be pipelined to any depth up to FQ_DEPTH.

---
 rtl/ifu_fq_if.sv | 68 ++++++
 rtl/ifu_fq.sv | 117 +++++++++++
 tb/tb_ifu_fq.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fq_if.sv
// Fetch unit bus: instruction memory request/response,
// branch predictor lookup, EXU redirect and decode-side queue head.
interface ifu_fq_if #(
    parameter int XLEN       = 32,
    parameter int INSTR_LEN  = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [XLEN-1:0]       reset_vector;
    logic [ADDR_WIDTH-1:0] instr_mem_addr;
    logic                  instr_mem_addr_valid;
    logic                  instr_mem_addr_ready;
    logic [XLEN-1:0]       instr_mem_tag_out;
    logic [INSTR_LEN-1:0]  instr_mem_rdata;
    logic                  instr_mem_rdata_valid;
    logic [XLEN-1:0]       instr_mem_tag_in;
    logic [XLEN-1:0]       pred_pc;
    logic                  pred_taken;
    logic [XLEN-1:0]       pred_target;
    logic                  pc_load;
    logic [XLEN-1:0]       pc_exu;
    logic                  pipe_stall;
    logic [INSTR_LEN-1:0]  instr;
    logic                  instr_valid;
    logic [XLEN-1:0]       instr_tag;
    logic                  predicted_taken_out;

    modport master (
        input  reset_vector,
        output instr_mem_addr,
        output instr_mem_addr_valid,
        input  instr_mem_addr_ready,
        output instr_mem_tag_out,
        input  instr_mem_rdata,
        input  instr_mem_rdata_valid,
        input  instr_mem_tag_in,
        output pred_pc,
        input  pred_taken,
        input  pred_target,
        input  pc_load,
        input  pc_exu,
        input  pipe_stall,
        output instr,
        output instr_valid,
        output instr_tag,
        output predicted_taken_out
    );

    modport slave (
        output reset_vector,
        input  instr_mem_addr,
        input  instr_mem_addr_valid,
        output instr_mem_addr_ready,
        input  instr_mem_tag_out,
        output instr_mem_rdata,
        output instr_mem_rdata_valid,
        output instr_mem_tag_in,
        input  pred_pc,
        output pred_taken,
        output pred_target,
        output pc_load,
        output pc_exu,
        output pipe_stall,
        input  instr,
        input  instr_valid,
        input  instr_tag,
        input  predicted_taken_out
    );
endinterface

// File: rtl/ifu_fq.sv
// Instruction fetch unit with credit-limited issue, a decoupled
// fetch queue and drop counting of stale responses after redirect.
module ifu_fq #(
    parameter int XLEN       = 32,
    parameter int INSTR_LEN  = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int FQ_DEPTH   = 4
) (
    input logic clk,
    input logic rst_n,
    ifu_fq_if.master bus
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam logic [PW+1:0] DEPTH_W = (PW+2)'(FQ_DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] IDX_ONE = PW'(1);

    typedef struct packed {
        logic                 taken;
        logic [INSTR_LEN-1:0] instr;
        logic [XLEN-1:0]      pc;
    } fq_entry_t;

    fq_entry_t             fq_mem [FQ_DEPTH];
    fq_entry_t             head;
    logic [XLEN-1:0]       fetch_pc;
    logic [PW:0]           wr_ptr;
    logic [PW:0]           rd_ptr;
    logic [PW:0]           fq_count;
    logic [PW:0]           inflight;
    logic [PW:0]           drop_cnt;
    logic [PW:0]           resp_w;
    logic [FQ_DEPTH-1:0]   pred_q;
    logic [PW-1:0]         pq_wr;
    logic [PW-1:0]         pq_rd;
    logic [PW+1:0]         credit;
    logic                  issue_ok;
    logic                  fire;
    logic                  resp;
    logic                  push;
    logic                  pop;
    logic                  fq_valid;

    assign fq_count = wr_ptr - rd_ptr;
    assign credit   = {1'b0, inflight} + {1'b0, fq_count};
    assign issue_ok = rst_n & ~bus.pc_load & (credit < DEPTH_W);
    assign fire     = issue_ok & bus.instr_mem_addr_ready;
    assign resp     = bus.instr_mem_rdata_valid & (inflight != '0);
    assign resp_w   = {{PW{1'b0}}, resp};
    assign fq_valid = fq_count != '0;
    assign push     = resp & (drop_cnt == '0) & ~bus.pc_load;
    assign pop      = fq_valid & ~bus.pipe_stall & ~bus.pc_load;
    assign head     = fq_mem[rd_ptr[PW-1:0]];

    assign bus.instr_mem_addr       = fetch_pc[ADDR_WIDTH-1:0];
    assign bus.instr_mem_addr_valid = issue_ok;
    assign bus.instr_mem_tag_out    = fetch_pc;
    assign bus.pred_pc              = fetch_pc;
    assign bus.instr                = head.instr;
    assign bus.instr_valid          = fq_valid;
    assign bus.instr_tag            = head.pc;
    assign bus.predicted_taken_out  = head.taken;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= bus.reset_vector;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            pred_q   <= '0;
            pq_wr    <= '0;
            pq_rd    <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_mem[i] <= '0;
            end
        end else begin
            if (fire) begin
                pred_q[pq_wr] <= bus.pred_taken;
                pq_wr         <= pq_wr + IDX_ONE;
            end
            if (resp) begin
                pq_rd <= pq_rd + IDX_ONE;
            end
            case ({fire, resp})
                2'b10:   inflight <= inflight + CNT_ONE;
                2'b01:   inflight <= inflight - CNT_ONE;
                default: inflight <= inflight;
            endcase
            if (bus.pc_load) begin
                rd_ptr   <= wr_ptr;
                fetch_pc <= bus.pc_exu;
                // inflight already covers responses still owed to drop_cnt
                drop_cnt <= (inflight > resp_w) ? inflight - resp_w : '0;
            end else begin
                if (fire) begin
                    fetch_pc <= bus.pred_taken ? bus.pred_target
                                               : fetch_pc + XLEN'(4);
                end
                if (resp && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CNT_ONE;
                end
                if (push) begin
                    fq_mem[wr_ptr[PW-1:0]] <= '{
                        taken: pred_q[pq_rd],
                        instr: bus.instr_mem_rdata,
                        pc:    bus.instr_mem_tag_in
                    };
                    wr_ptr <= wr_ptr + CNT_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + CNT_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_ifu_fq.sv
// Scoreboard bench for ifu_fq: driver models memory and predictor,
// monitor checks every instruction consumed by decode.
module tb_ifu_fq;
    localparam int XLEN = 32;
    localparam int IL   = 32;
    localparam int AW   = 16;
    localparam int D    = 4;

    typedef struct {
        logic [31:0] tag;
        logic        taken;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        int          due;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_fq_if #(.XLEN(XLEN), .INSTR_LEN(IL), .ADDR_WIDTH(AW)) bus ();

    ifu_fq #(
        .XLEN(XLEN), .INSTR_LEN(IL), .ADDR_WIDTH(AW), .FQ_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    exp_t        exp_q[$];
    req_t        mq[$];
    logic [31:0] req_exp[$];
    int          req_idx = 0;
    int          checks = 0;
    int          errors = 0;
    int          k = 1;
    int          icyc = 0;
    int          first_fire = -1;
    int          first_valid = -1;
    int          nfire = 0;
    logic        rst_v = 1'b0;
    logic        stall_v = 1'b1;
    logic        load_v = 1'b0;
    logic        rdy_v = 1'b1;
    logic        rand_rdy = 1'b0;
    logic        pred_en = 1'b0;
    logic        last_av = 1'b0;
    logic        last_iv = 1'b0;
    logic [31:0] exu_v = '0;
    logic [31:0] rv_v = '0;
    logic [31:0] pred_at = '0;
    logic [31:0] pred_to = '0;

    function automatic logic [31:0] mdata(input logic [31:0] pc);
        return pc ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic step();
        req_t r;
        @(negedge clk);
        rst_n = rst_v;
        bus.reset_vector = rv_v;
        bus.pipe_stall = stall_v;
        bus.pc_load = load_v;
        bus.pc_exu = exu_v;
        bus.instr_mem_addr_ready =
            rand_rdy ? 1'($urandom_range(0, 1)) : rdy_v;
        bus.instr_mem_rdata_valid = 1'b0;
        if (!rst_v) begin
            mq.delete();
        end else if (mq.size() > 0 && mq[0].due <= icyc) begin
            r = mq.pop_front();
            bus.instr_mem_rdata_valid = 1'b1;
            bus.instr_mem_tag_in = r.pc;
            bus.instr_mem_rdata = mdata(r.pc);
        end
        #1;
        bus.pred_taken = pred_en && (bus.pred_pc == pred_at);
        bus.pred_target = pred_to;
        #1;
        last_av = bus.instr_mem_addr_valid;
        last_iv = bus.instr_valid;
        if (rst_v) begin
            if (bus.instr_mem_addr_valid && req_idx < req_exp.size()) begin
                check("req_tag", bus.instr_mem_tag_out, req_exp[req_idx]);
                check("req_addr", {16'h0, bus.instr_mem_addr},
                      {16'h0, req_exp[req_idx][15:0]});
            end
            if (bus.instr_mem_addr_valid && bus.instr_mem_addr_ready) begin
                mq.push_back('{pc: bus.instr_mem_tag_out, due: icyc + k});
                nfire++;
                req_idx++;
                if (first_fire < 0) first_fire = icyc;
            end
            if (bus.instr_valid && first_valid < 0) first_valid = icyc;
        end
        @(posedge clk);
        if (rst_v) icyc++;
    endtask

    task automatic do_reset(input logic [31:0] rv);
        rst_v = 1'b0;
        stall_v = 1'b1;
        load_v = 1'b0;
        rv_v = rv;
        step();
        step();
        #1;
        check("rst_instr_valid", {31'h0, bus.instr_valid}, 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_tag", bus.instr_tag, 32'h0);
        check("rst_pred_out", {31'h0, bus.predicted_taken_out}, 32'h0);
        check("rst_addr_valid", {31'h0, bus.instr_mem_addr_valid}, 32'h0);
        check("rst_pred_pc", bus.pred_pc, rv);
        rst_v = 1'b1;
        icyc = 0;
        first_fire = -1;
        first_valid = -1;
        nfire = 0;
        req_idx = 0;
        req_exp.delete();
        exp_q.delete();
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d left, required 0", nm,
                     exp_q.size());
            exp_q.delete();
        end
        stall_v = 1'b1;
        step();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.instr_valid && !bus.pipe_stall
                && !bus.pc_load) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: tag %h, required none",
                             bus.instr_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_tag", bus.instr_tag, e.tag);
                    check("mon_instr", bus.instr, mdata(e.tag));
                    check("mon_pred", {31'h0, bus.predicted_taken_out},
                          {31'h0, e.taken});
                end
            end
        end
    end

    initial begin
        bus.reset_vector = '0;
        bus.instr_mem_addr_ready = 1'b0;
        bus.instr_mem_rdata = '0;
        bus.instr_mem_rdata_valid = 1'b0;
        bus.instr_mem_tag_in = '0;
        bus.pred_taken = 1'b0;
        bus.pred_target = '0;
        bus.pc_load = 1'b0;
        bus.pc_exu = '0;
        bus.pipe_stall = 1'b1;

        // straight-line stream, k = 1
        k = 1;
        do_reset(32'h1000);
        for (int i = 0; i < 10; i++) req_exp.push_back(32'h1000 + 4 * i);
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{tag: 32'h1000 + 4 * i, taken: 1'b0});
        stall_v = 1'b0;
        drain("s1", 40);
        check("s1_first_fire", first_fire, 0);
        check("s1_latency", first_valid - first_fire, 2);

        // credit limit under a held stall
        do_reset(32'h1000);
        repeat (10) step();
        #1;
        check("s2_fired", nfire, 4);
        check("s2_addr_valid", {31'h0, bus.instr_mem_addr_valid}, 32'h0);
        check("s2_head_valid", {31'h0, bus.instr_valid}, 32'h1);
        check("s2_head_tag", bus.instr_tag, 32'h1000);
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{tag: 32'h1000 + 4 * i, taken: 1'b0});
        stall_v = 1'b0;
        drain("s2", 40);

        // taken prediction at 0x1008
        do_reset(32'h1000);
        pred_en = 1'b1;
        pred_at = 32'h1008;
        pred_to = 32'h2000;
        req_exp = '{32'h1000, 32'h1004, 32'h1008, 32'h2000, 32'h2004};
        exp_q.push_back('{tag: 32'h1000, taken: 1'b0});
        exp_q.push_back('{tag: 32'h1004, taken: 1'b0});
        exp_q.push_back('{tag: 32'h1008, taken: 1'b1});
        exp_q.push_back('{tag: 32'h2000, taken: 1'b0});
        exp_q.push_back('{tag: 32'h2004, taken: 1'b0});
        exp_q.push_back('{tag: 32'h2008, taken: 1'b0});
        stall_v = 1'b0;
        drain("s3", 40);
        pred_en = 1'b0;

        // redirect with three requests in flight, k = 3
        do_reset(32'h1000);
        k = 3;
        req_exp = '{32'h1000, 32'h1004, 32'h1008, 32'h3000, 32'h3004};
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{tag: 32'h3000 + 4 * i, taken: 1'b0});
        stall_v = 1'b0;
        repeat (3) step();
        check("s4_inflight", nfire, 3);
        load_v = 1'b1;
        exu_v = 32'h3000;
        step();
        check("s4_no_issue", {31'h0, last_av}, 32'h0);
        load_v = 1'b0;
        step();
        check("s4_fq_empty", {31'h0, last_iv}, 32'h0);
        drain("s4", 40);
        check("s4_redirect_latency", first_valid, 8);

        // redirect with a response and a valid head, k = 2
        do_reset(32'h1000);
        k = 2;
        req_exp = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h4000};
        exp_q.push_back('{tag: 32'h1000, taken: 1'b0});
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{tag: 32'h4000 + 4 * i, taken: 1'b0});
        stall_v = 1'b0;
        repeat (4) step();
        load_v = 1'b1;
        exu_v = 32'h4000;
        step();
        load_v = 1'b0;
        drain("s5", 40);

        // PC wrap with random ready gaps
        do_reset(32'hFFFF_FFF8);
        k = 1;
        rand_rdy = 1'b1;
        req_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8,
                    32'hC};
        for (int i = 0; i < 6; i++)
            exp_q.push_back('{tag: req_exp[i], taken: 1'b0});
        stall_v = 1'b0;
        drain("s6", 200);
        rand_rdy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
